// File: rtl/sdram_arbiter.sv
// sdram_arbiter: registered, handshaked scheduler sharing one 8-bit SDRAM port
// between four requesters (0=ioctl download, 1=hard-reset cleanup, 2=Z80 CPU, 3=cassette).
// Only one transaction is in flight at a time. Fixed priority ioctl > cleanup > cpu > cas.
// The cassette is eligible only while cas_window_i is high in the IDLE sample cycle.
//
// Optional macro ARB_AGE_EN: adds an 8-bit age counter for a pending cassette request.
// At AGE_MAX the cassette ranks above the cpu and ignores the refresh window.
//
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   req_i/we_i [3:0]        per-port request level (held until ack) and write flag
//   addr_i [4*AW-1:0]       per-port byte address, port0 at LSB
//   wdata_i [31:0]          per-port write byte, port0 at LSB
//   cas_window_i            CPU refresh window, gates the cassette request
//   ack_o [3:0]             one-cycle completion pulse per port
//   rdata_o [7:0]           read byte, valid in the ack cycle and held afterwards
//   err_o                   one-cycle pulse when a transaction is aborted by timeout
//   mem_*                   sdram controller side (addr, din, rd/we pulses, dout, ready)
//   busy_o                  transaction in flight
module sdram_arbiter #(
    parameter int unsigned AW      = 23,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned AGE_MAX = 255
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [3:0]      req_i,
    input  logic [3:0]      we_i,
    input  logic [4*AW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    input  logic            cas_window_i,
    output logic [3:0]      ack_o,
    output logic [7:0]      rdata_o,
    output logic            err_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [7:0]      mem_din_o,
    output logic            mem_rd_o,
    output logic            mem_we_o,
    input  logic [7:0]      mem_dout_i,
    input  logic            mem_ready_i,
    output logic            busy_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitLo, StWaitHi} state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [TW-1:0]   timer_q;
    logic            timed_out;

    logic            grant_valid;
    logic [1:0]      grant_sel;
    logic            cas_first;
    logic            cas_elig;
    logic            start;

`ifdef ARB_AGE_EN
    logic [7:0] age_q, age_d;
    logic       cas_granted;

    assign cas_first = (age_q == 8'(AGE_MAX));
    assign cas_elig  = req_i[3] & (cas_window_i | cas_first);
`else
    assign cas_first = 1'b0;
    assign cas_elig  = req_i[3] & cas_window_i;
`endif

    // Priority encoder; a promoted cassette slots in between cleanup and cpu.
    always_comb begin
        grant_valid = 1'b1;
        grant_sel   = 2'd0;
        if (req_i[0]) begin
            grant_sel = 2'd0;
        end else if (req_i[1]) begin
            grant_sel = 2'd1;
        end else if (cas_first && req_i[3]) begin
            grant_sel = 2'd3;
        end else if (req_i[2]) begin
            grant_sel = 2'd2;
        end else if (cas_elig) begin
            grant_sel = 2'd3;
        end else begin
            grant_valid = 1'b0;
        end
    end

    assign start     = (state_q == StIdle) && mem_ready_i && grant_valid;
    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        ack_o    = 4'b0000;
        err_o    = 1'b0;
        mem_rd_o = 1'b0;
        mem_we_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    grant_d = grant_sel;
                    we_d    = we_i[grant_sel];
                    addr_d  = addr_i[grant_sel*AW +: AW];
                    din_d   = wdata_i[grant_sel*8 +: 8];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_rd_o = ~we_q;
                mem_we_o = we_q;
                state_d  = StWaitLo;
            end
            StWaitLo: begin
                if (!mem_ready_i) begin
                    state_d = StWaitHi;
                end else if (timed_out) begin
                    err_o   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitHi: begin
                if (mem_ready_i) begin
                    ack_o[grant_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_dout_i;
                    end
                    state_d = StIdle;
                end else if (timed_out) begin
                    err_o   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset abandons the transaction silently; the controller finishes on its own.
        if (reset) begin
            ack_o    = 4'b0000;
            err_o    = 1'b0;
            mem_rd_o = 1'b0;
            mem_we_o = 1'b0;
            rdata_d  = rdata_q;
        end
    end

    // rdata_o shows the captured byte already in the ack cycle.
    assign rdata_o    = rdata_d;
    assign mem_addr_o = addr_q;
    assign mem_din_o  = din_q;
    assign busy_o     = (state_q != StIdle);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    // Timer counts cycles spent in the current state and restarts on every entry.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
        end
    end

`ifdef ARB_AGE_EN
    assign cas_granted = start && (grant_sel == 2'd3);

    always_comb begin
        age_d = age_q;
        if (!req_i[3] || ack_o[3]) begin
            age_d = 8'h00;
        end else if ((state_q == StIdle) && !cas_granted && (age_q != 8'(AGE_MAX))) begin
            age_d = age_q + 8'h01;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            age_q <= 8'h00;
        end else begin
            age_q <= age_d;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a behavioural sdram model plus a scoreboard of
// expected transactions (port, direction, address, data) checked at issue and at ack.
module tb_sdram_arbiter;

    localparam int unsigned AW      = 23;
    localparam int unsigned TIMEOUT = 64;

    logic            clk_sys = 1'b0;
    logic            reset   = 1'b1;
    logic [3:0]      req_i   = 4'b0000;
    logic [3:0]      we_i    = 4'b0000;
    logic [4*AW-1:0] addr_i  = '0;
    logic [31:0]     wdata_i = '0;
    logic            cas_window_i = 1'b0;
    logic [3:0]      ack_o;
    logic [7:0]      rdata_o;
    logic            err_o;
    logic [AW-1:0]   mem_addr_o;
    logic [7:0]      mem_din_o;
    logic            mem_rd_o;
    logic            mem_we_o;
    logic [7:0]      mem_dout_i  = 8'h00;
    logic            mem_ready_i = 1'b1;
    logic            busy_o;

    sdram_arbiter #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT),
        .AGE_MAX (255)
    ) u_dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .cas_window_i (cas_window_i),
        .ack_o        (ack_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_din_o    (mem_din_o),
        .mem_rd_o     (mem_rd_o),
        .mem_we_o     (mem_we_o),
        .mem_dout_i   (mem_dout_i),
        .mem_ready_i  (mem_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk_sys = ~clk_sys;

    // sdram model: ready drops after a command, stays low busy_cyc cycles, then rises with data.
    logic       nodrop   = 1'b0;
    int         busy_cyc = 5;
    logic [7:0] rd_val   = 8'h00;
    int         mcnt     = 0;

    always @(posedge clk_sys) begin
        if (mem_rd_o || mem_we_o) begin
            if (!nodrop) begin
                mem_ready_i <= 1'b0;
                mcnt        <= busy_cyc;
            end
        end else if (!mem_ready_i) begin
            if (mcnt <= 1) begin
                mem_ready_i <= 1'b1;
                mem_dout_i  <= rd_val;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    typedef struct {
        int          port;
        bit          we;
        logic [22:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_issue = 0;
    int   n_ack   = 0;
    int   n_err   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_port(input int p, input bit we, input logic [22:0] a,
                              input logic [7:0] d);
        addr_i[p*AW +: AW] = a;
        wdata_i[p*8 +: 8]  = d;
        we_i[p]            = we;
        req_i[p]           = 1'b1;
    endtask

    task automatic push(input int p, input bit we, input logic [22:0] a, input logic [7:0] d);
        txn_t t;
        t.port = p;
        t.we   = we;
        t.addr = a;
        t.data = d;
        sb_q.push_back(t);
    endtask

    // One cycle, sampled at the falling edge; requesters drop req as soon as they see ack.
    task automatic step();
        txn_t t;
        @(negedge clk_sys);
        if (mem_rd_o || mem_we_o) begin
            n_issue++;
            if (sb_q.size() > 0) begin
                check("issue_addr", 32'(mem_addr_o), 32'(sb_q[0].addr));
                check("issue_we", 32'(mem_we_o), 32'(sb_q[0].we));
                if (sb_q[0].we) check("issue_din", 32'(mem_din_o), 32'(sb_q[0].data));
            end else begin
                check("issue_unexpected", sb_q.size(), 1);
            end
        end
        if (err_o) n_err++;
        if (ack_o != 4'b0000) begin
            n_ack++;
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                check("ack_port", 32'(ack_o), 32'(4'b0001 << t.port));
                if (!t.we) check("rdata", 32'(rdata_o), 32'(t.data));
            end else begin
                check("ack_unexpected", sb_q.size(), 1);
            end
            req_i = req_i & ~ack_o;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    task automatic wait_issue(input string tag, input int budget, output int steps);
        int base = n_issue;
        steps = 0;
        while (n_issue == base && steps < budget) begin
            step();
            steps++;
        end
        check(tag, 32'(n_issue - base), 1);
    endtask

    initial begin
        int   s;
        int   base_issue;
        int   base_ack;
        int   base_err;
        int   cpu_n;
        bit   cas_done;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rdwe", 32'({mem_rd_o, mem_we_o}), 0);
        check("rst_addr", 32'(mem_addr_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);

        // 1: single cpu read
        busy_cyc = 5;
        rd_val   = 8'hA5;
        base_issue = n_issue;
        push(2, 1'b0, 23'h012345, 8'hA5);
        drive_port(2, 1'b0, 23'h012345, 8'h00);
        drain("t1_drain", 100);
        check("t1_issues", n_issue - base_issue, 1);
        step();
        check("t1_rdata_hold", 32'(rdata_o), 32'hA5);
        check("t1_idle", 32'(busy_o), 0);

        // 2: ioctl write and cpu read in the same cycle; ioctl first
        rd_val = 8'h66;
        push(0, 1'b1, 23'h000010, 8'h3C);
        push(2, 1'b0, 23'h000020, 8'h66);
        drive_port(0, 1'b1, 23'h000010, 8'h3C);
        drive_port(2, 1'b0, 23'h000020, 8'h00);
        drain("t2_drain", 200);

        // 3: cassette blocked while the refresh window is closed
        rd_val = 8'hC3;
        base_issue = n_issue;
        drive_port(3, 1'b0, 23'h000333, 8'h00);
        cas_window_i = 1'b0;
        repeat (100) step();
        check("t3_blocked", n_issue - base_issue, 0);
        push(3, 1'b0, 23'h000333, 8'hC3);
        cas_window_i = 1'b1;
        wait_issue("t3_issue", 2, s);
        check("t3_latency", s, 1);
        cas_window_i = 1'b0;   // closing the window mid-transaction must not matter
        drain("t3_drain", 100);

        // 4: sdram never drops ready -> timeout, no ack, request re-served
        nodrop   = 1'b1;
        rd_val   = 8'h17;
        base_ack = n_ack;
        base_err = n_err;
        base_issue = n_issue;
        push(2, 1'b0, 23'h000444, 8'h17);
        drive_port(2, 1'b0, 23'h000444, 8'h00);
        wait_issue("t4_issue", 10, s);
        s = 0;
        while (n_err == base_err && s < 200) begin
            step();
            s++;
        end
        nodrop = 1'b0;
        check("t4_err_seen", n_err - base_err, 1);
        check("t4_err_cycles", s, TIMEOUT);
        check("t4_no_ack", n_ack - base_ack, 0);
        drain("t4_drain", 200);
        check("t4_reissue", n_issue - base_issue, 2);
        check("t4_err_once", n_err - base_err, 1);

        // 5: reset during WAIT_HI
        rd_val   = 8'h5A;
        base_ack = n_ack;
        base_issue = n_issue;
        base_err = n_err;
        push(2, 1'b0, 23'h0ABCDE, 8'h5A);
        drive_port(2, 1'b0, 23'h0ABCDE, 8'h00);
        wait_issue("t5_issue", 10, s);
        step();
        step();
        check("t5_in_wait_hi", 32'({busy_o, mem_ready_i}), 32'b10);
        reset = 1'b1;
        @(negedge clk_sys);
        check("t5_rst_ack", 32'(ack_o), 0);
        check("t5_rst_err", 32'(err_o), 0);
        check("t5_rst_busy", 32'(busy_o), 0);
        check("t5_rst_rdwe", 32'({mem_rd_o, mem_we_o}), 0);
        check("t5_rst_addr", 32'(mem_addr_o), 0);
        check("t5_rst_rdata", 32'(rdata_o), 0);
        reset = 1'b0;
        check("t5_no_ack", n_ack - base_ack, 0);
        drain("t5_drain", 200);
        check("t5_reissue", n_issue - base_issue, 2);
        check("t5_no_err", n_err - base_err, 0);

        // 6: cpu saturates the port while cas waits with a closed window
        busy_cyc = 2;
        cpu_n    = 0;
        cas_done = 1'b0;
        cas_window_i = 1'b0;
        drive_port(2, 1'b0, 23'h000600, 8'h00);
        drive_port(3, 1'b0, 23'h000700, 8'h00);
        for (int i = 0; i < 3000 && !cas_done; i++) begin
            @(negedge clk_sys);
            if (ack_o[2]) cpu_n++;
            if (ack_o[3]) cas_done = 1'b1;
        end
`ifdef ARB_AGE_EN
        check("t6_cas_granted", 32'(cas_done), 1);
        check("t6_cpu_before_cas", 32'(cpu_n >= 250 && cpu_n <= 256), 1);
`else
        check("t6_cas_never", 32'(cas_done), 0);
        check("t6_cpu_served", 32'(cpu_n > 200), 1);
`endif
        req_i = 4'b0000;
        s = 0;
        while ((busy_o || !mem_ready_i) && s < 100) begin
            @(negedge clk_sys);
            s++;
        end
        check("t6_settle", 32'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single 8-bit SDRAM port between four requesters: ROM/CAS download (ioctl), hard-reset cleanup, Z80 CPU and the cassette reader.
- Sits between those requesters and the sdram controller, replacing the combinational address/data/we muxing with a registered, handshaked scheduler.
- Fixed priority with a cassette refresh-window rule; one transaction in flight at a time.

Parameters:
- AW, 23, SDRAM byte address width.
- TIMEOUT, 64, max cycles to wait for each mem_ready transition before aborting the transaction.
- AGE_MAX, 255, cycles a pending cassette request may wait before promotion (used only with ARB_AGE_EN).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_i  in  4  request per port; [0]=ioctl, [1]=cleanup, [2]=cpu, [3]=cas. Level, held until ack.
- we_i  in  4  per-port write flag, sampled with req.
- addr_i  in  4*AW  per-port address, packed with port0 at LSB.
- wdata_i  in  32  per-port write byte, packed with port0 at LSB.
- cas_window_i  in  1  high during CPU refresh (~cpu_rfsh_n); cassette is eligible only while high.
- ack_o  out  4  one-cycle completion pulse per port.
- rdata_o  out  8  read byte, valid in the ack cycle, held until the next completion.
- err_o  out  1  one-cycle pulse on timeout abort.
- mem_addr_o  out  AW  to sdram addr.
- mem_din_o  out  8  to sdram din.
- mem_rd_o  out  1  to sdram rd, one-cycle pulse.
- mem_we_o  out  1  to sdram we, one-cycle pulse.
- mem_dout_i  in  8  from sdram dout.
- mem_ready_i  in  1  sdram ready: high = idle/accepting; drops after a command; rises when done.
- busy_o  out  1  transaction in flight.

Behaviour:
- Reset values: all outputs 0, mem_addr_o 0, rdata_o 0, state IDLE, grant 0, timer 0.
- States:
  - IDLE: if mem_ready_i=1 and an eligible request exists, latch grant, addr, we and wdata, then go to ISSUE.
  - ISSUE: assert mem_rd_o or mem_we_o for exactly one cycle with the latched addr/din, then go to WAIT_LO.
  - WAIT_LO: wait for mem_ready_i=0, then go to WAIT_HI.
  - WAIT_HI: wait for mem_ready_i=1. On that cycle, capture rdata_o from mem_dout_i (reads only) and pulse ack_o[grant]. Go to IDLE.
- mem_addr_o and mem_din_o stay stable from ISSUE until the exit from WAIT_HI.
- Latency: the earliest ack is 3 cycles after the request is sampled, plus the sdram busy time. A requester seeing ack may deassert req_i or keep it high for back-to-back access. Re-arbitration takes one IDLE cycle.
- Priority: ioctl > cleanup > cpu > cas. The cas request is eligible only when cas_window_i=1 in the IDLE sample cycle. Later changes to cas_window_i do not affect a granted transaction.
- Request lines and data are sampled only in IDLE; changes mid-transaction are ignored. A deasserted req on the granted port still completes and acks.
- Timeout: the timer resets on each state entry. If it reaches TIMEOUT in WAIT_LO or WAIT_HI, pulse err_o, do not ack, and return to IDLE. The requester keeps req_i high and is re-served.
- Simultaneous events: all four requests in one cycle → ioctl served first, then cleanup, and so on. A cas request with cas_window_i=0 is never served, even when it is the only request.
- Reset mid-transaction: return to IDLE next cycle, no ack and no err. The sdram controller is not aborted. The next grant waits for mem_ready_i=1.

Optional Feature:
- ARB_AGE_EN. When defined, an 8-bit age counter increments each IDLE cycle in which cas is requesting but not granted, saturating at AGE_MAX. The counter clears on cas ack or when req_i[3]=0.
- While age == AGE_MAX, cas ranks above cpu but below ioctl and cleanup, and cas_window_i is ignored.
- When undefined, no counter exists and pure fixed priority plus the window rule apply.

Test Plan:
1. Single cpu read, addr 0x012345, sdram model busy 5 cycles returning 0xA5 → one mem_rd_o pulse at 0x012345, ack_o=4'b0100 once, rdata_o=0xA5.
2. Requests ioctl write 0x000010/0x3C and cpu read 0x000020 in the same cycle → ioctl write is issued first with din 0x3C; cpu read follows after its ack; two acks in order [0], then [2].
3. Cas request held with cas_window_i=0 for 100 cycles, then 1 → no issue while 0; issued within 1 cycle of the window opening; ack_o[3] pulses.
4. sdram model holds mem_ready_i=1 after the command (never drops) → err_o pulses after TIMEOUT=64 cycles in WAIT_LO, no ack, request re-issued.
5. reset asserted during WAIT_HI → next cycle all outputs 0, no ack. After reset, a pending cpu request is re-served normally.
6. ARB_AGE_EN defined, cpu requesting continuously, cas requesting with window 0 → after 255 IDLE cycles cas is granted ahead of cpu; with the macro undefined, cas is never granted.
